// File: rtl/output_driver_pkg.sv
// Shared definitions for the outputDriver command protocol: op codes, pulse
// modes, command-word field positions and the sequencer state encoding.
package output_driver_pkg;

  // Command op codes carried in the top two bits of every command word.
  localparam logic [1:0] OP_SET_MODE    = 2'd0;
  localparam logic [1:0] OP_SET_DELAY   = 2'd1;
  localparam logic [1:0] OP_SET_WIDTH   = 2'd2;
  localparam logic [1:0] OP_SET_PATTERN = 2'd3;

  // Pulse modes understood by the outputDriver.
  localparam logic [1:0] M_DISABLED       = 2'd0;
  localparam logic [1:0] M_PULSE          = 2'd1;
  localparam logic [1:0] M_PATTERN_SINGLE = 2'd2;
  localparam logic [1:0] M_PATTERN_LOOP   = 2'd3;

  // Command-word field positions.
  localparam int CMD_WORD_WIDTH = 32;
  localparam int OP_MSB         = 31;
  localparam int OP_LSB         = 30;
  localparam int PAYLOAD_WIDTH  = 30;
  localparam int MODE_MSB       = 1;
  localparam int MODE_LSB       = 0;

  // Sequencer states; see the table in output_driver_config_sequencer.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_DELAY = 3'd1,
    WR_WIDTH = 3'd2,
    WR_MODE  = 3'd3,
    HOLDOFF  = 3'd4
  } seqState_t;

  // Round-robin pointer: which requester wins the next tie.
  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } rrPtr_t;

  // Builds a command word from an op code and a zero-extended payload.
  function automatic logic [CMD_WORD_WIDTH-1:0] makeCmdWord(
    input logic [1:0]               op,
    input logic [PAYLOAD_WIDTH-1:0] payload
  );
    logic [CMD_WORD_WIDTH-1:0] word;
    word                 = '0;
    word[OP_MSB:OP_LSB]  = op;
    word[PAYLOAD_WIDTH-1:0] = payload;
    return word;
  endfunction

  // Mode word: op code plus the two mode bits, everything else zero.
  function automatic logic [CMD_WORD_WIDTH-1:0] makeModeWord(
    input logic [1:0] mode
  );
    logic [CMD_WORD_WIDTH-1:0] word;
    word                    = '0;
    word[OP_MSB:OP_LSB]     = OP_SET_MODE;
    word[MODE_MSB:MODE_LSB] = mode;
    return word;
  endfunction

endpackage

// File: rtl/output_driver_config_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter. Readies are combinational; the pointer only
// moves when both requesters compete, so a lone requester never steals the
// next tie from the other side.
module rr_arbiter2
  import output_driver_pkg::*;
(
  input  logic sysClk,
  input  logic sysRst_n,
  input  logic enable,
  input  logic aValid,
  input  logic bValid,
  output logic aReady,
  output logic bReady
);

  rrPtr_t ptr;

  // Grant: a single valid side wins outright, a tie goes to the pointer side.
  always_comb begin
    aReady = enable && aValid && (!bValid || (ptr == PTR_A));
    bReady = enable && bValid && (!aValid || (ptr == PTR_B));
  end

  // Pointer hand-over after each contested grant.
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      ptr <= PTR_A;
    end else if (enable && aValid && bValid) begin
      ptr <= (ptr == PTR_A) ? PTR_B : PTR_A;
    end
  end

endmodule

// File: rtl/output_driver_config_sequencer.sv
// Serialises pulse-configuration requests from two requesters into the
// three-word outputDriver command protocol (delay, width, mode) on a shared
// 32-bit bus with a per-channel strobe. The mode word goes last because it
// fires the driver's domain-crossing toggle; the holdoff that follows gives
// the EVR domain time to absorb the update.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | arbitrate, accept and latch a request
//   WR_DELAY | delay word on gpioOut, strobe asserted
//   WR_WIDTH | width word on gpioOut, strobe asserted
//   WR_MODE  | mode word on gpioOut, strobe asserted
//   HOLDOFF  | strobes low, gpioOut holds the mode word, count down
module output_driver_config_sequencer
  import output_driver_pkg::*;
#(
  parameter int CHANNEL_COUNT      = 8,
  parameter int CHANNEL_SEL_WIDTH  = 3,
  parameter int SERDES_WIDTH       = 4,
  parameter int COARSE_DELAY_WIDTH = 22,
  parameter int COARSE_WIDTH_WIDTH = 20,
  parameter int HOLDOFF_CYCLES     = 16
) (
  input  logic                                       sysClk,
  input  logic                                       sysRst_n,
  input  logic                                       aValid,
  output logic                                       aReady,
  input  logic [CHANNEL_SEL_WIDTH-1:0]               aChannel,
  input  logic [1:0]                                 aMode,
  input  logic [COARSE_DELAY_WIDTH+SERDES_WIDTH-1:0] aDelayInfo,
  input  logic [COARSE_WIDTH_WIDTH+SERDES_WIDTH-1:0] aWidthInfo,
  input  logic                                       bValid,
  output logic                                       bReady,
  input  logic [CHANNEL_SEL_WIDTH-1:0]               bChannel,
  input  logic [1:0]                                 bMode,
  input  logic [COARSE_DELAY_WIDTH+SERDES_WIDTH-1:0] bDelayInfo,
  input  logic [COARSE_WIDTH_WIDTH+SERDES_WIDTH-1:0] bWidthInfo,
  output logic [CHANNEL_COUNT-1:0]                   csrStrobe,
  output logic [31:0]                                gpioOut,
  output logic                                       busy,
  output logic                                       badChannel
);

  localparam int DELAY_INFO_W = COARSE_DELAY_WIDTH + SERDES_WIDTH;
  localparam int WIDTH_INFO_W = COARSE_WIDTH_WIDTH + SERDES_WIDTH;
  localparam int HOLD_CNT_W   = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [HOLD_CNT_W-1:0]        HOLD_LOAD  = HOLD_CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CHANNEL_SEL_WIDTH:0]   CH_LIMIT   = (CHANNEL_SEL_WIDTH + 1)'(CHANNEL_COUNT);
  localparam logic [CHANNEL_COUNT-1:0]     STROBE_ONE = CHANNEL_COUNT'(1);

  seqState_t                 state;
  logic [HOLD_CNT_W-1:0]     holdCnt;
  logic [WIDTH_INFO_W-1:0]   reqWidth;
  logic [1:0]                reqMode;

  logic                         arbEnable;
  logic                         accept;
  logic [CHANNEL_SEL_WIDTH-1:0] selChannel;
  logic [1:0]                   selMode;
  logic [DELAY_INFO_W-1:0]      selDelay;
  logic [WIDTH_INFO_W-1:0]      selWidth;
  logic                         chanBad;
  logic [CHANNEL_COUNT-1:0]     chanOneHot;

  // Arbitration is only open while the sequencer is idle.
  assign arbEnable = (state == IDLE);

  rr_arbiter2 uArbiter (
    .sysClk   (sysClk),
    .sysRst_n (sysRst_n),
    .enable   (arbEnable),
    .aValid   (aValid),
    .bValid   (bValid),
    .aReady   (aReady),
    .bReady   (bReady)
  );

  // Select the granted requester's fields and classify its channel.
  always_comb begin
    accept     = aReady | bReady;
    selChannel = aReady ? aChannel   : bChannel;
    selMode    = aReady ? aMode      : bMode;
    selDelay   = aReady ? aDelayInfo : bDelayInfo;
    selWidth   = aReady ? aWidthInfo : bWidthInfo;
    chanBad    = ({1'b0, selChannel} >= CH_LIMIT);
    chanOneHot = STROBE_ONE << selChannel;
  end

  // Sequencer FSM with registered bus, strobe and status outputs. The delay
  // word is launched straight from the accepted request so it appears in the
  // first cycle after accept; width and mode come from the latched copy.
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      state      <= IDLE;
      holdCnt    <= '0;
      reqWidth   <= '0;
      reqMode    <= M_DISABLED;
      csrStrobe  <= '0;
      gpioOut    <= '0;
      busy       <= 1'b0;
      badChannel <= 1'b0;
    end else begin
      badChannel <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            reqWidth <= selWidth;
            reqMode  <= selMode;
            if (chanBad) begin
              // Request is consumed but never reaches a driver.
              badChannel <= 1'b1;
            end else begin
              state     <= WR_DELAY;
              busy      <= 1'b1;
              csrStrobe <= chanOneHot;
              gpioOut   <= makeCmdWord(OP_SET_DELAY, PAYLOAD_WIDTH'(selDelay));
            end
          end
        end
        WR_DELAY: begin
          state   <= WR_WIDTH;
          gpioOut <= makeCmdWord(OP_SET_WIDTH, PAYLOAD_WIDTH'(reqWidth));
        end
        WR_WIDTH: begin
          state   <= WR_MODE;
          gpioOut <= makeModeWord(reqMode);
        end
        WR_MODE: begin
          state     <= HOLDOFF;
          csrStrobe <= '0;
          holdCnt   <= HOLD_LOAD;
        end
        HOLDOFF: begin
          if (holdCnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            holdCnt <= holdCnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          csrStrobe <= '0;
        end
      endcase
    end
  end

endmodule
